// File: rtl/params_pkg.sv
// Shared widths and writeback types: the memory access size encoding and the
// entry buffered per source between EX/MEM and the register file.
package params_pkg;

    localparam int REGISTER_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int NUM_WB_SRC     = 2;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD,
        MEM_RSVD
    } mem_size_e;

    typedef struct packed {
        logic [REGISTER_WIDTH-1:0] wr_reg;
        logic [DATA_WIDTH-1:0]     data;
        logic                      is_load;
        mem_size_e                 mem_size;
        logic                      mem_unsigned;
        logic [1:0]                addr_lo;
    } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source synchronous FIFO of writeback entries. Push and pop are expected
// to be pre-qualified by the caller (push only when not full, pop only when not empty).
module wb_src_fifo
    import params_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_commit_unit.sv
// Multi-source writeback stage: per-source FIFOs, round-robin arbitration onto
// one registered register-file write port, and load lane extraction at pop.
module wb_commit_unit
    import params_pkg::*;
#(
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int NUM_SRC        = 2,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NUM_SRC-1:0]                       src_valid_i,
    output logic [NUM_SRC-1:0]                       src_ready_o,
    input  logic [NUM_SRC-1:0][REGISTER_WIDTH-1:0]   src_wr_reg_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]       src_data_i,
    input  logic [NUM_SRC-1:0]                       src_is_load_i,
    input  logic [NUM_SRC-1:0][1:0]                  src_mem_size_i,
    input  logic [NUM_SRC-1:0]                       src_mem_unsigned_i,
    input  logic [NUM_SRC-1:0][1:0]                  src_addr_lo_i,
    output logic                                     rf_wr_en_o,
    output logic [REGISTER_WIDTH-1:0]                rf_wr_reg_o,
    output logic [DATA_WIDTH-1:0]                    rf_wr_data_o,
    output logic                                     retire_o,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] retire_src_o,
    output logic                                     busy_o
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_entry_t          in_entry [NUM_SRC];
    wb_entry_t          head     [NUM_SRC];
    wb_entry_t          head_sel;
    logic [NUM_SRC-1:0] empty, full, push, pop;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx, scan_idx;

    logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      rf_wr_en_q, rf_wr_en_d;
    logic [REGISTER_WIDTH-1:0] rf_wr_reg_q, rf_wr_reg_d;
    logic [DATA_WIDTH-1:0]     rf_wr_data_q, rf_wr_data_d;
    logic                      retire_q, retire_d;
    logic [SRC_W-1:0]          retire_src_q, retire_src_d;

    // Valid/ready: a beat transfers on source i when src_valid_i[i] && src_ready_o[i];
    // ready depends only on registered FIFO occupancy (and reset), never on valid.
    assign src_ready_o = rst_i ? '0 : ~full;
    assign push        = src_valid_i & src_ready_o;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_entry[i].wr_reg       = src_wr_reg_i[i];
            in_entry[i].data         = src_data_i[i];
            in_entry[i].is_load      = src_is_load_i[i];
            in_entry[i].mem_size     = mem_size_e'(src_mem_size_i[i]);
            in_entry[i].mem_unsigned = src_mem_unsigned_i[i];
            in_entry[i].addr_lo      = src_addr_lo_i[i];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_src_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .push_i     (push[i]),
            .push_data_i(in_entry[i]),
            .pop_i      (pop[i]),
            .head_o     (head[i]),
            .empty_o    (empty[i]),
            .full_o     (full[i])
        );
    end

    // Scan from the RR pointer; the first non-empty FIFO wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (!grant_valid && !empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        pop = '0;
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
    end

    assign head_sel = head[grant_idx];

    function automatic logic [DATA_WIDTH-1:0] extract(input wb_entry_t e);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = 8'(e.data >> {e.addr_lo, 3'b000});
        h = 16'(e.data >> {e.addr_lo[1], 4'b0000});
        r = DATA_WIDTH'(e.data);
        if (e.is_load) begin
            case (e.mem_size)
                MEM_BYTE: r = {{(DATA_WIDTH-8){~e.mem_unsigned & b[7]}}, b};
                MEM_HALF: r = {{(DATA_WIDTH-16){~e.mem_unsigned & h[15]}}, h};
                default:  r = DATA_WIDTH'(e.data);
            endcase
        end
        return r;
    endfunction

    // r0 entries still retire and consume the slot but never write.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        retire_d     = grant_valid;
        retire_src_d = retire_src_q;
        rf_wr_en_d   = 1'b0;
        rf_wr_reg_d  = rf_wr_reg_q;
        rf_wr_data_d = rf_wr_data_q;
        if (grant_valid) begin
            rr_ptr_d     = SRC_W'((int'(grant_idx) + 1) % NUM_SRC);
            retire_src_d = grant_idx;
            rf_wr_en_d   = (head_sel.wr_reg != '0);
            rf_wr_reg_d  = REGISTER_WIDTH'(head_sel.wr_reg);
            rf_wr_data_d = extract(head_sel);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            retire_q     <= 1'b0;
            retire_src_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_reg_q  <= '0;
            rf_wr_data_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            retire_q     <= retire_d;
            retire_src_q <= retire_src_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_reg_q  <= rf_wr_reg_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    assign rf_wr_en_o   = rf_wr_en_q;
    assign rf_wr_reg_o  = rf_wr_reg_q;
    assign rf_wr_data_o = rf_wr_data_q;
    assign retire_o     = retire_q;
    assign retire_src_o = retire_src_q;
    assign busy_o       = ~rst_i & ((~&empty) | retire_q);

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit (2 sources, depth 2): directed scenarios plus a
// per-source expected queue checked whenever a commit appears on the rf port.
module tb_wb_commit_unit;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      src_valid = '0;
    logic [1:0]      src_ready;
    logic [1:0][4:0] src_wr_reg = '0;
    logic [1:0][31:0] src_data = '0;
    logic [1:0]      src_is_load = '0;
    logic [1:0][1:0] src_mem_size = '0;
    logic [1:0]      src_mem_unsigned = '0;
    logic [1:0][1:0] src_addr_lo = '0;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_reg;
    logic [31:0]     rf_wr_data;
    logic            retire;
    logic [0:0]      retire_src;
    logic            busy;

    int              tests_run = 0;
    int              tests_failed = 0;
    logic [36:0]     exp_q0[$];
    logic [36:0]     exp_q1[$];
    int              commit_log[$];
    logic [1:0]      seen_lo, seen_hi;

    wb_commit_unit #(.NUM_SRC(2), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_wr_reg_i(src_wr_reg), .src_data_i(src_data),
        .src_is_load_i(src_is_load), .src_mem_size_i(src_mem_size),
        .src_mem_unsigned_i(src_mem_unsigned), .src_addr_lo_i(src_addr_lo),
        .rf_wr_en_o(rf_wr_en), .rf_wr_reg_o(rf_wr_reg), .rf_wr_data_o(rf_wr_data),
        .retire_o(retire), .retire_src_o(retire_src), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_data(input logic [31:0] w, input logic ld,
                                               input logic [1:0] sz, input logic u,
                                               input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        if (!ld) return w;
        if (sz == 2'd0) return u ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'd1) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    task automatic set_beat(input int s, input logic [4:0] r, input logic [31:0] d,
                            input logic ld, input logic [1:0] sz, input logic u,
                            input logic [1:0] lo);
        src_wr_reg[s]       = r;
        src_data[s]         = d;
        src_is_load[s]      = ld;
        src_mem_size[s]     = sz;
        src_mem_unsigned[s] = u;
        src_addr_lo[s]      = lo;
    endtask

    task automatic push_exp(input int s);
        logic [36:0] e;
        e = {src_wr_reg[s], model_data(src_data[s], src_is_load[s], src_mem_size[s],
                                       src_mem_unsigned[s], src_addr_lo[s])};
        if (s == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Advance one clock and check any commit against the expected queues.
    task automatic cycle();
        logic [36:0] got, exp;
        @(posedge clk);
        #1;
        tests_run++;
        if (retire === 1'b1) begin
            commit_log.push_back(int'(retire_src));
            got = {rf_wr_reg, rf_wr_data};
            if ((retire_src == 1'b0 && exp_q0.size() == 0) ||
                (retire_src == 1'b1 && exp_q1.size() == 0)) begin
                tests_failed++;
                $display("FAIL unexpected_commit src=%0d got=%h exp=none", retire_src, got);
            end else begin
                if (retire_src == 1'b0) exp = exp_q0.pop_front();
                else                    exp = exp_q1.pop_front();
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL commit_payload src=%0d got=%h exp=%h", retire_src, got, exp);
                end
                tests_run++;
                if (rf_wr_en !== (exp[36:32] != 5'd0)) begin
                    tests_failed++;
                    $display("FAIL commit_wr_en got=%b exp=%b", rf_wr_en, exp[36:32] != 5'd0);
                end
            end
        end else if (rf_wr_en !== 1'b0 && retire !== 1'bx) begin
            tests_failed++;
            $display("FAIL idle_wr_en got=%b exp=0", rf_wr_en);
        end
    endtask

    task automatic send(input int s, input logic [4:0] r, input logic [31:0] d,
                        input logic ld, input logic [1:0] sz, input logic u,
                        input logic [1:0] lo);
        set_beat(s, r, d, ld, sz, u, lo);
        src_valid[s] = 1'b1;
        tests_run++;
        for (int t = 0; t < 50; t++) begin
            if (src_ready[s] === 1'b1) begin
                push_exp(s);
                cycle();
                src_valid[s] = 1'b0;
                return;
            end
            cycle();
        end
        tests_failed++;
        $display("FAIL send_timeout src=%0d got=ready_low exp=ready_high", s);
        src_valid[s] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && busy !== 1'b0; t++) cycle();
        tests_run++;
        if (busy !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got=busy%b/q%0d/q%0d exp=busy0/q0/q0", busy, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic run_stream(input int n0, input int n1, input bit rnd);
        int         left [2];
        logic [1:0] act;
        int         t;
        left[0] = n0; left[1] = n1; act = '0; seen_lo = '0; seen_hi = '0; t = 0;
        while ((left[0] > 0 || left[1] > 0) && t < 500) begin
            for (int s = 0; s < 2; s++) begin
                if (!act[s] && left[s] > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                    if (rnd)
                        set_beat(s, 5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)),
                                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                    else
                        set_beat(s, 5'(s * 16 + 1 + left[s] % 15), $urandom(), 1'b0, 2'd0, 1'b0, 2'd0);
                    act[s] = 1'b1;
                end
            end
            src_valid = act;
            for (int s = 0; s < 2; s++) begin
                if (act[s]) begin
                    if (src_ready[s] === 1'b1) begin
                        seen_hi[s] = 1'b1;
                        push_exp(s);
                        act[s] = 1'b0;
                        left[s]--;
                    end else begin
                        seen_lo[s] = 1'b1;
                    end
                end
            end
            cycle();
            t++;
        end
        src_valid = '0;
        tests_run++;
        if (left[0] != 0 || left[1] != 0) begin
            tests_failed++;
            $display("FAIL stream_timeout got=%0d/%0d exp=0/0", left[0], left[1]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = '0;
        cycle();
        cycle();
        tests_run++;
        if ({src_ready, busy, rf_wr_en, rf_wr_reg, rf_wr_data, retire, retire_src} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got=%b/%b/%b/%h/%h/%b/%b exp=all_zero",
                     src_ready, busy, rf_wr_en, rf_wr_reg, rf_wr_data, retire, retire_src);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (src_ready !== 2'b11 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got=ready%b/busy%b exp=ready11/busy0", src_ready, busy);
        end
    endtask

    task automatic test_alu();
        send(0, 5'd5, 32'h1234_5678, 1'b0, 2'd2, 1'b0, 2'd0);
        tests_run++;
        if (rf_wr_en !== 1'b0 || retire !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_no_bypass got=en%b/ret%b exp=en0/ret0", rf_wr_en, retire);
        end
        cycle();
        tests_run++;
        if ({rf_wr_en, retire, retire_src, rf_wr_reg, rf_wr_data} !== {1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL alu_commit got=en%b/ret%b/src%0d/r%0d/%h exp=en1/ret1/src0/r5/12345678",
                     rf_wr_en, retire, retire_src, rf_wr_reg, rf_wr_data);
        end
        cycle();
        tests_run++;
        if ({rf_wr_en, retire, rf_wr_reg, rf_wr_data} !== {1'b0, 1'b0, 5'd5, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL alu_after got=en%b/ret%b/r%0d/%h exp=en0/ret0/r5/12345678",
                     rf_wr_en, retire, rf_wr_reg, rf_wr_data);
        end
        wait_idle();
    endtask

    task automatic test_loads();
        send(1, 5'd9, 32'h0080_0000, 1'b1, 2'd0, 1'b0, 2'd2);
        cycle();
        tests_run++;
        if (rf_wr_data !== 32'hFFFF_FF80 || retire_src !== 1'b1 || rf_wr_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_byte_signed got=%h/src%0d exp=ffffff80/src1", rf_wr_data, retire_src);
        end
        send(1, 5'd10, 32'h0080_0000, 1'b1, 2'd0, 1'b1, 2'd2);
        cycle();
        tests_run++;
        if (rf_wr_data !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL load_byte_unsigned got=%h exp=00000080", rf_wr_data);
        end
        send(1, 5'd11, 32'h8001_0000, 1'b1, 2'd1, 1'b0, 2'd3);
        cycle();
        tests_run++;
        if (rf_wr_data !== 32'hFFFF_8001) begin
            tests_failed++;
            $display("FAIL load_half_signed got=%h exp=ffff8001", rf_wr_data);
        end
        wait_idle();
    endtask

    task automatic test_r0();
        send(0, 5'd0, 32'h0000_DEAD, 1'b0, 2'd2, 1'b0, 2'd0);
        cycle();
        tests_run++;
        if (retire !== 1'b1 || rf_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL r0_commit got=ret%b/en%b exp=ret1/en0", retire, rf_wr_en);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int bad;
        commit_log.delete();
        run_stream(8, 8, 1'b0);
        wait_idle();
        bad = 0;
        for (int i = 1; i < commit_log.size(); i++)
            if (commit_log[i] == commit_log[i-1]) bad++;
        tests_run++;
        if (commit_log.size() != 16 || bad != 0) begin
            tests_failed++;
            $display("FAIL rr_alternate got=n%0d/repeats%0d exp=n16/repeats0", commit_log.size(), bad);
        end
        tests_run++;
        if (seen_lo !== 2'b11 || seen_hi !== 2'b11) begin
            tests_failed++;
            $display("FAIL ready_toggle got=lo%b/hi%b exp=lo11/hi11", seen_lo, seen_hi);
        end
    endtask

    task automatic test_full();
        // A lone src0 commit leaves the RR pointer at src1.
        send(0, 5'd20, 32'hAAAA_0001, 1'b0, 2'd2, 1'b0, 2'd0);
        wait_idle();
        set_beat(0, 5'd21, 32'hAAAA_0002, 1'b0, 2'd2, 1'b0, 2'd0);
        set_beat(1, 5'd22, 32'hBBBB_0001, 1'b0, 2'd2, 1'b0, 2'd0);
        src_valid = 2'b11;
        tests_run++;
        if (src_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL full_c0_ready got=%b exp=11", src_ready);
        end
        if (src_ready[0] === 1'b1) push_exp(0);
        if (src_ready[1] === 1'b1) push_exp(1);
        cycle();
        src_valid = 2'b01;
        set_beat(0, 5'd23, 32'hAAAA_0003, 1'b0, 2'd2, 1'b0, 2'd0);
        tests_run++;
        if (src_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_c1_ready got=%b exp=1", src_ready[0]);
        end
        if (src_ready[0] === 1'b1) push_exp(0);
        cycle();
        set_beat(0, 5'd24, 32'hAAAA_0004, 1'b0, 2'd2, 1'b0, 2'd0);
        tests_run++;
        if (src_ready[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pop_cycle_ready got=%b exp=0", src_ready[0]);
        end
        if (src_ready[0] === 1'b1) push_exp(0);
        cycle();
        tests_run++;
        if (src_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_after_pop_ready got=%b exp=1", src_ready[0]);
        end
        if (src_ready[0] === 1'b1) push_exp(0);
        cycle();
        src_valid = '0;
        wait_idle();
    endtask

    task automatic test_random();
        run_stream(16, 16, 1'b1);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        commit_log.delete();
        set_beat(0, 5'd3, $urandom(), 1'b0, 2'd2, 1'b0, 2'd0);
        set_beat(1, 5'd4, $urandom(), 1'b0, 2'd2, 1'b0, 2'd0);
        src_valid = 2'b11;
        if (src_ready[0] === 1'b1) push_exp(0);
        if (src_ready[1] === 1'b1) push_exp(1);
        cycle();
        set_beat(0, 5'd12, $urandom(), 1'b0, 2'd2, 1'b0, 2'd0);
        set_beat(1, 5'd13, $urandom(), 1'b0, 2'd2, 1'b0, 2'd0);
        if (src_ready[0] === 1'b1) push_exp(0);
        if (src_ready[1] === 1'b1) push_exp(1);
        cycle();
        src_valid = '0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (src_ready !== 2'b00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_hold got=ready%b/busy%b exp=ready00/busy0", src_ready, busy);
        end
        tests_run++;
        if (exp_q0.size() + exp_q1.size() != 3) begin
            tests_failed++;
            $display("FAIL mid_reset_queued got=%0d exp=3", exp_q0.size() + exp_q1.size());
        end
        cycle();
        tests_run++;
        if ({busy, rf_wr_en, rf_wr_reg, rf_wr_data, retire, retire_src} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs got=%b/%b/%h/%h/%b/%b exp=all_zero",
                     busy, rf_wr_en, rf_wr_reg, rf_wr_data, retire, retire_src);
        end
        exp_q0.delete();
        exp_q1.delete();
        rst = 1'b0;
        repeat (8) cycle();
        tests_run++;
        if (commit_log.size() != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_dropped got=commits%0d/busy%b exp=commits1/busy0", commit_log.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_r0();
        test_back_to_back();
        test_full();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Parametrised multi-source writeback stage. Accepts results from NUM_SRC producers (e.g. ALU pipe, load pipe) through valid/ready handshakes and buffers each in a small per-source FIFO.
- Arbitrates round-robin onto a single registered register-file write port.
- Performs load-data lane extraction with sign/zero extension.
- Sits between the EX/MEM stages and the register file; replaces the single-source combinational writeback mux.

Parameters:
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5): register index width.
- DATA_WIDTH, params_pkg::DATA_WIDTH (32): datapath width; load extraction is defined for 32.
- NUM_SRC, 2: number of writeback sources, legal range 1..8.
- FIFO_DEPTH, 2: entries per source FIFO, a power of two ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- src_valid_i  in  [NUM_SRC]  source i presents a result
- src_ready_o  out  [NUM_SRC]  source i FIFO can accept
- src_wr_reg_i  in  [NUM_SRC][REGISTER_WIDTH]  destination register
- src_data_i  in  [NUM_SRC][DATA_WIDTH]  ALU result or raw memory word
- src_is_load_i  in  [NUM_SRC]  apply load extraction
- src_mem_size_i  in  [NUM_SRC][2]  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- src_mem_unsigned_i  in  [NUM_SRC]  zero-extend when 1, sign-extend when 0
- src_addr_lo_i  in  [NUM_SRC][2]  load address bits [1:0]
- rf_wr_en_o  out  1  register-file write enable (registered)
- rf_wr_reg_o  out  REGISTER_WIDTH  write index (registered)
- rf_wr_data_o  out  DATA_WIDTH  write data (registered)
- retire_o  out  1  one entry committed this cycle, including r0 targets
- retire_src_o  out  $clog2(NUM_SRC) (min 1)  source of the committed entry
- busy_o  out  1  any FIFO non-empty or output valid

Behaviour:
- Reset (rst_i high at posedge): all FIFOs emptied, counts 0; RR pointer 0; rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o, retire_o, retire_src_o all 0.
- While rst_i is high, src_ready_o is 0 and busy_o is 0.
- Reset mid-operation drops all queued entries silently.
- Handshake:
  - Transfer on source i in cycle n when src_valid_i[i] and src_ready_o[i].
  - src_ready_o[i] = (count_i < FIFO_DEPTH), from registered state only; no combinational path from any valid.
  - A full FIFO does not accept in the same cycle it pops.
  - Push and pop on a non-full, non-empty FIFO in one cycle leaves the count unchanged.
  - Payload is captured at transfer; source inputs are don't-care otherwise.
- Latency and throughput:
  - An entry transferred in cycle n is earliest visible on the rf_* outputs in cycle n+2: FIFO write at end of n, arbitration and pop in n+1, output register loaded at end of n+1.
  - No bypass.
  - Throughput: one commit per cycle across all sources.
- Arbitration:
  - Each cycle, grant the first non-empty FIFO at or after the RR pointer, modulo NUM_SRC.
  - On grant to i, the pointer becomes (i+1) mod NUM_SRC. No grant leaves the pointer unchanged.
  - Starvation-free: a waiting head is granted within NUM_SRC cycles.
- Output register:
  - On grant: retire_o=1, retire_src_o=i, rf_wr_reg_o=head reg, rf_wr_data_o=extracted data, rf_wr_en_o=(head reg != 0).
  - With no grant: retire_o=0 and rf_wr_en_o=0; rf_wr_reg_o and rf_wr_data_o hold their previous values.
  - r0 entries consume their grant slot but never assert rf_wr_en_o.
- Load extraction, applied at pop when is_load=1, on a 32-bit word w with lo=addr_lo:
  - byte: w[8*lo +: 8], extended to DATA_WIDTH.
  - half: w[16*lo[1] +: 16]; lo[0] is ignored.
  - word/reserved: w unchanged; lo is ignored.
  - Extension is sign or zero per the unsigned bit.
  - is_load=0 passes data unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. A count of FIFO_DEPTH means full; a count of 0 means empty and the FIFO is never granted.

Decomposition:
- params_pkg additions:
  - typedef enum logic [1:0] mem_size_e {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_RSVD}.
  - Constant NUM_WB_SRC = 2.
  - Packed struct wb_entry_t {wr_reg, data, is_load, mem_size, mem_unsigned, addr_lo}.
- One sub-module, wb_src_fifo: a synchronous FIFO of wb_entry_t, instantiated NUM_SRC times via generate.
- Arbiter and extraction logic stay in wb_commit_unit.

Test Plan:
- After reset, src0 sends ALU {reg 5, data 0x1234_5678} in cycle 3 -> cycle 5: rf_wr_en_o=1, reg 5, data 0x12345678, retire_src_o=0; cycle 6: rf_wr_en_o=0.
- src1 load, byte, signed, addr_lo=2, word 0x00_80_00_00 -> rf_wr_data_o=0xFFFFFF80; the same entry with unsigned=1 -> 0x00000080; half, signed, lo=3, word 0x8001_0000 -> 0xFFFF8001.
- Both sources hold valid continuously with distinct regs -> commits alternate 0,1,0,1 and each source's ready toggles per the depth-2 fill pattern; no loss or duplication checked by scoreboard.
- Hold src0 valid with no pops possible (fill to FIFO_DEPTH before the first grant) -> src_ready_o[0]=0 once count=2 and remains 0 through the cycle in which the head pops; the new beat is accepted the cycle after.
- Entry to reg 0 with data 0xDEAD -> retire_o=1, rf_wr_en_o=0.
- Queue 3 entries, then assert rst_i for one cycle -> all outputs 0 next cycle, busy_o=0, and none of the queued entries is ever committed.
